// File: rtl/fp_mult_collect.sv
// rtl/fp_mult_collect.sv - FIFO collecting floating-point multiplier products with sticky status and error count
module fp_mult_collect #(
    parameter  int SIG_WIDTH = 17,
    parameter  int EXP_WIDTH = 6,
    parameter  int DEPTH     = 4,
    localparam int W         = SIG_WIDTH + EXP_WIDTH + 1,
    localparam int LW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_z,
    input  logic [7:0]    in_status,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_z,
    output logic [7:0]    out_status,
    input  logic          clr_sticky,
    output logic [7:0]    sticky,
    output logic [7:0]    err_count,
    output logic [LW-1:0] level
);

    localparam int PW = $clog2(DEPTH);

    // Canonical quiet NaN written in place of any product flagged invalid
    localparam logic [W-1:0] NAN_Z = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [5:0]    r_sticky;
    logic [7:0]    r_err_count;

    logic [W-1:0]  r_mem_z  [DEPTH];
    logic [7:0]    r_mem_st [DEPTH];

    logic          w_push;
    logic          w_pop;
    logic          w_counts;
    logic [W-1:0]  w_store_z;

    // Handshake qualification and the value actually written into storage
    always_comb begin
        in_ready  = (r_level != LW'(DEPTH));
        out_valid = (r_level != '0);
        w_push    = in_valid & in_ready;
        w_pop     = out_valid & out_ready;
        w_counts  = in_status[2] | in_status[4];
        w_store_z = in_status[2] ? NAN_Z : in_z;
    end

    // Storage array is not reset; only pointers and level define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_z[r_wptr]  <= w_store_z;
            r_mem_st[r_wptr] <= in_status;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky status flags and saturating error count; a clear on a push edge keeps that push's contribution
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky    <= '0;
            r_err_count <= '0;
        end else if (clr_sticky) begin
            r_sticky    <= w_push ? in_status[5:0] : 6'd0;
            r_err_count <= (w_push && w_counts) ? 8'd1 : 8'd0;
        end else if (w_push) begin
            r_sticky <= r_sticky | in_status[5:0];
            if (w_counts && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    // Head entry is presented only while the FIFO holds data, otherwise zero
    always_comb begin
        out_z      = out_valid ? r_mem_z[r_rptr]  : '0;
        out_status = out_valid ? r_mem_st[r_rptr] : 8'd0;
        sticky     = {2'b00, r_sticky};
        err_count  = r_err_count;
        level      = r_level;
    end

endmodule

// File: doc/fp_mult_collect.md
FP_MULT_COLLECT -- requirements
Module: fp_mult_collect

Interface
REQ-001 SHALL have parameter SIG_WIDTH, default 17, meaning significand field width of the multiplier product.
REQ-002 SHALL have parameter EXP_WIDTH, default 6, meaning exponent field width; word width W = SIG_WIDTH+EXP_WIDTH+1 (24 at defaults).
REQ-003 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, >=2).
REQ-004 SHALL have one clock; reset is asynchronous and active-low: ports clk and rst_n.
REQ-005 SHALL have ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  multiplier product present
- in_ready  out  1  block can accept product
- in_z  in  W  product from DW_fp_mult (sign W-1, exp W-2:SIG_WIDTH, sig SIG_WIDTH-1:0)
- in_status  in  8  DW status (0 zero, 1 inf, 2 invalid, 3 tiny, 4 huge, 5 inexact, 7:6 reserved)
- out_valid  out  1  head entry available
- out_ready  in  1  consumer takes head
- out_z  out  W  head product
- out_status  out  8  head status
- clr_sticky  in  1  clear sticky flags and error count
- sticky  out  8  OR of accepted status bits 5:0; bits 7:6 always 0
- err_count  out  8  saturating count of accepted entries with status[2] or status[4] set
- level  out  clog2(DEPTH)+1  current occupancy

Function
REQ-006 SHALL implement a DEPTH-entry FIFO of {z,status} pairs using wrap-around read/write pointers.
REQ-007 SHALL assert in_ready = (level != DEPTH), combinationally from registered level.
REQ-008 SHALL accept (push) when in_valid & in_ready at a rising edge.
REQ-009 SHALL assert out_valid = (level != 0); out_z/out_status SHALL show the head entry whenever out_valid=1, with value 0 when empty.
REQ-010 SHALL pop when out_valid & out_ready at a rising edge.
REQ-011 SHALL give 1-cycle latency: an entry pushed at edge N is visible at out_z after edge N when the FIFO was empty.
REQ-012 SHALL, on simultaneous push and pop, keep level unchanged and advance both pointers; when full, in_ready=0 blocks the push even if a pop occurs in the same cycle.
REQ-013 SHALL ignore in_valid when in_ready=0 and out_ready when out_valid=0 (no pointer or level change).
REQ-014 SHALL replace stored z with canonical NaN (sign 0, exponent all ones, sig MSB 1, rest 0; 0x7F0000 at defaults) when the pushed in_status[2]=1; status stored unchanged.
REQ-015 SHALL update sticky on each push as sticky | in_status[5:0].
REQ-016 SHALL increment err_count on each push with in_status[2]|in_status[4], saturating at 255.
REQ-017 SHALL, when clr_sticky=1 on a push edge, load sticky = in_status[5:0] and err_count = 1 if the pushed entry counts, else 0; with no push, clr_sticky loads 0 into both.
REQ-018 SHALL preserve data order exactly; no entry may be dropped or duplicated, including across pointer wrap.

Reset
REQ-019 SHALL, while rst_n=0, force pointers=0, level=0, in_ready=1, out_valid=0, out_z=0, out_status=0, sticky=0, err_count=0, independent of clk.
REQ-020 SHALL discard all FIFO contents on reset assertion mid-operation; storage array need not be cleared.

Verification
REQ-021 Reset then single push in_z=0x2EF0A3, status=0x20 -> next cycle out_valid=1, out_z=0x2EF0A3, sticky=0x20, level=1.
REQ-022 Push 4 entries (1,2,3,4) with out_ready=0 -> level=4, in_ready=0; 5th push (5) ignored; drain -> outputs 1,2,3,4 in order, level=0.
REQ-023 Level=2, simultaneous push 0x000007 and pop for 6 cycles -> level stays 2, pointers wrap, outputs in push order.
REQ-024 Push in_z=0x123456 with status=0x04 -> out_z=0x7F0000, out_status=0x04, err_count=1, sticky=0x04.
REQ-025 300 pushes with status=0x10 (draining each) -> err_count=255; clr_sticky with push status=0x01 -> sticky=0x01, err_count=0.
REQ-026 Assert rst_n=0 asynchronously with level=3 -> out_valid=0, level=0, in_ready=1 immediately, before next clk edge.
